// File: rtl/burst_master_port.sv
// burst_master_port: bus master that serialises a burst transaction onto
// one-bit write/read links. The address goes out once per burst, MSB first.
// The master arbitrates with breq/bgrant, checks the slave ack after the
// slave-select bits, and retries after a stall timeout.
// Optional feature: define BURST_MASTER_PORT_SPLIT_EN to honour slave split
// during reads.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for m_start
// REQ     | bus requested, waiting for bgrant
// FETCH   | load the address shift register, clear the timeout
// ADDR_1  | send slave-select bits, check ack on the last one
// ADDR_2  | send the remaining address bits
// LOAD    | capture one write beat from m_wr_data
// WR_DATA | send one write beat
// RD_DATA | shift in one read beat
// SPLIT   | slave split: hold the bus and all counters
// BACKOFF | release the bus for one cycle after a timeout
// DONE    | completion pulse, then back to IDLE
module burst_master_port #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int SLAVE_BITS = 4,
  parameter int MAX_BURST  = 4,
  parameter int TIMEOUT    = 64,
  parameter int MAX_RETRY  = 3,
  localparam int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic          clk,
  input  logic          rstn,
  output logic          mode,
  output logic          wr_bus,
  input  logic          rd_bus,
  input  logic          ack,
  output logic          master_valid,
  input  logic          slave_ready,
  output logic          master_ready,
  input  logic          slave_valid,
  output logic          breq,
  input  logic          bgrant,
  input  logic          split,
  input  logic [AW-1:0] m_addr,
  input  logic          m_mode,
  input  logic [LW-1:0] m_len,
  input  logic          m_start,
  input  logic [DW-1:0] m_wr_data,
  output logic          m_wr_req,
  output logic [DW-1:0] m_rd_data,
  output logic          m_rd_valid,
  output logic          m_busy,
  output logic          m_done,
  output logic          m_err
);

  localparam int SRW = (AW > DW) ? AW : DW;
  localparam int BCW = $clog2(SRW + 1);
  localparam int TW  = $clog2(TIMEOUT);
  localparam int RW  = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    IDLE, REQ, FETCH, ADDR_1, ADDR_2, LOAD, WR_DATA, RD_DATA, SPLIT, BACKOFF, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            mode_q, mode_d;
  logic [LW-1:0]   len_q, len_d;
  logic [SRW-1:0]  sr_q, sr_d;
  logic [BCW-1:0]  bit_q, bit_d;
  logic [LW-1:0]   beat_q, beat_d;
  logic [TW-1:0]   to_q, to_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            err_q, err_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            stall;
  logic            xfer_w, xfer_r;

  assign breq         = !(state_q == IDLE || state_q == BACKOFF || state_q == DONE);
  assign master_valid = (state_q == ADDR_1) || (state_q == ADDR_2) || (state_q == WR_DATA);
  assign master_ready = (state_q == RD_DATA);
  assign m_busy       = (state_q != IDLE);
  assign m_wr_req     = (state_q == LOAD);
  assign m_done       = (state_q == DONE);
  assign mode         = mode_q;
  assign wr_bus       = master_valid & sr_q[SRW-1];
  assign m_rd_data    = rd_data_q;
  assign m_rd_valid   = rd_valid_q;
  assign m_err        = err_q;
  assign xfer_w       = master_valid & slave_ready;
  assign xfer_r       = master_ready & slave_valid;

`ifndef BURST_MASTER_PORT_SPLIT_EN
  logic unused_split;
  assign unused_split = split;
`endif

  // state and datapath register bank
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mode_q     <= 1'b0;
      len_q      <= '0;
      sr_q       <= '0;
      bit_q      <= '0;
      beat_q     <= '0;
      to_q       <= '0;
      retry_q    <= '0;
      err_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      sr_q       <= sr_d;
      bit_q      <= bit_d;
      beat_q     <= beat_d;
      to_q       <= to_d;
      retry_q    <= retry_d;
      err_q      <= err_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // next-state, bit/beat sequencing and stall timeout
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mode_d     = mode_q;
    len_d      = len_q;
    sr_d       = sr_q;
    bit_d      = bit_q;
    beat_d     = beat_q;
    to_d       = to_q;
    retry_d    = retry_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    stall      = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_start) begin
          addr_d  = m_addr;
          mode_d  = m_mode;
          len_d   = (m_len == '0 || m_len > LW'(MAX_BURST)) ? LW'(MAX_BURST) : m_len;
          err_d   = 1'b0;
          retry_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bgrant) begin
          to_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        sr_d    = SRW'(addr_q) << (SRW - AW);
        bit_d   = '0;
        state_d = ADDR_1;
      end
      ADDR_1: begin
        if (xfer_w) begin
          sr_d = sr_q << 1;
          to_d = '0;
          if (bit_q == BCW'(SLAVE_BITS - 1)) begin
            bit_d = '0;
            if (ack) begin
              state_d = ADDR_2;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      ADDR_2: begin
        if (xfer_w) begin
          sr_d = sr_q << 1;
          to_d = '0;
          if (bit_q == BCW'(AW - SLAVE_BITS - 1)) begin
            bit_d   = '0;
            state_d = mode_q ? LOAD : RD_DATA;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      LOAD: begin
        sr_d    = SRW'(m_wr_data) << (SRW - DW);
        bit_d   = '0;
        state_d = WR_DATA;
      end
      WR_DATA: begin
        if (xfer_w) begin
          sr_d = sr_q << 1;
          to_d = '0;
          if (bit_q == BCW'(DW - 1)) begin
            bit_d   = '0;
            beat_d  = beat_q + 1'b1;
            state_d = (beat_q == len_q - 1'b1) ? DONE : LOAD;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
      end
      RD_DATA: begin
        if (xfer_r) begin
          sr_d = {sr_q[SRW-2:0], rd_bus};
          to_d = '0;
          if (bit_q == BCW'(DW - 1)) begin
            bit_d      = '0;
            beat_d     = beat_q + 1'b1;
            rd_data_d  = {sr_q[DW-2:0], rd_bus};
            rd_valid_d = 1'b1;
            if (beat_q == len_q - 1'b1) state_d = DONE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          stall = 1'b1;
        end
`ifdef BURST_MASTER_PORT_SPLIT_EN
        // a split freezes the timeout; a bit taken in the same cycle still counts
        if (split) begin
          stall = 1'b0;
          if (state_d == RD_DATA) state_d = SPLIT;
        end
`endif
      end
`ifdef BURST_MASTER_PORT_SPLIT_EN
      SPLIT: begin
        if (!split) state_d = RD_DATA;
      end
`endif
      BACKOFF: begin
        bit_d  = '0;
        beat_d = '0;
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = REQ;
        end else begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        bit_d   = '0;
        beat_d  = '0;
        to_d    = '0;
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (stall) begin
      to_d = to_q + 1'b1;
      if (to_q == TW'(TIMEOUT - 2)) state_d = BACKOFF;
    end
  end

endmodule

// File: tb/tb_burst_master_port.sv
// tb_burst_master_port: drives burst_master_port with a reactive serial
// slave and compares the observed bit stream, read words, completion and
// error status against expectations built from the transaction itself.
module tb_burst_master_port;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SB = 4;
  localparam int MB = 4;
  localparam int TO = 64;
  localparam int MR = 3;
  localparam int LW = $clog2(MB) + 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          mode, wr_bus, rd_bus, ack, master_valid, slave_ready;
  logic          master_ready, slave_valid, breq, bgrant, split;
  logic [AW-1:0] m_addr;
  logic          m_mode;
  logic [LW-1:0] m_len;
  logic          m_start;
  logic [DW-1:0] m_wr_data;
  logic          m_wr_req;
  logic [DW-1:0] m_rd_data;
  logic          m_rd_valid, m_busy, m_done, m_err;

  burst_master_port #(.AW(AW), .DW(DW), .SLAVE_BITS(SB), .MAX_BURST(MB),
                      .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .wr_bus(wr_bus), .rd_bus(rd_bus),
    .ack(ack), .master_valid(master_valid), .slave_ready(slave_ready),
    .master_ready(master_ready), .slave_valid(slave_valid), .breq(breq),
    .bgrant(bgrant), .split(split), .m_addr(m_addr), .m_mode(m_mode),
    .m_len(m_len), .m_start(m_start), .m_wr_data(m_wr_data),
    .m_wr_req(m_wr_req), .m_rd_data(m_rd_data), .m_rd_valid(m_rd_valid),
    .m_busy(m_busy), .m_done(m_done), .m_err(m_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] wdat [MB];
  logic [DW-1:0] rdat [MB];
  logic          wr_bits [$];
  logic [DW-1:0] rd_words [$];
  int            stall_runs [$];
  int            n_done, n_wrreq, n_backoff, done_cyc;
  logic          err_done, breq_done;
  int            grant_pct, ready_pct, split_len;
  logic          ack_v, poke_start;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rd_stream(input int p);
    logic [DW-1:0] w;
    if (p >= MB * DW) return 1'b0;
    w = rdat[p / DW];
    return w[DW - 1 - (p % DW)];
  endfunction

  function automatic int eff_len(input int len);
    return (len == 0 || len > MB) ? MB : len;
  endfunction

  // one transaction with a reactive slave; ends on the negedge after m_done
  task automatic run_txn(input logic [AW-1:0] addr, input logic md, input logic [LW-1:0] len,
                         input int budget);
    int   wr_idx = 0;
    int   rd_ptr = 0;
    int   stall = 0;
    int   split_left = 0;
    bit   split_used = 0;
    wr_bits.delete(); rd_words.delete(); stall_runs.delete();
    n_done = 0; n_wrreq = 0; n_backoff = 0; done_cyc = -1;
    err_done = 1'b0; breq_done = 1'b1;
    @(negedge clk);
    m_addr = addr; m_mode = md; m_len = len; m_start = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    for (int cyc = 0; cyc < budget && done_cyc < 0; cyc++) begin
      if (m_done) begin
        n_done++; done_cyc = cyc; err_done = m_err; breq_done = breq;
      end
      if (m_rd_valid) rd_words.push_back(m_rd_data);
      if (m_busy && !breq && !m_done) begin
        n_backoff++; stall_runs.push_back(stall); stall = 0;
        wr_idx = 0; rd_ptr = 0; wr_bits.delete(); rd_words.delete();
      end
      bgrant      = ($urandom_range(99) < grant_pct);
      slave_ready = ($urandom_range(99) < ready_pct);
      slave_valid = ($urandom_range(99) < ready_pct);
      ack         = ack_v;
      split       = 1'b0;
      if (master_ready && rd_ptr == DW + 3 && !split_used && split_len > 0) begin
        split_left = split_len; split_used = 1;
      end
      if (split_left > 0) begin
        split = 1'b1;
        split_left--;
`ifdef BURST_MASTER_PORT_SPLIT_EN
        slave_valid = 1'b0;
`endif
      end
      rd_bus = rd_stream(rd_ptr);
      if (master_valid && slave_ready) begin
        wr_bits.push_back(wr_bus); stall = 0;
      end else if (master_valid) begin
        stall++;
      end
      if (master_ready && slave_valid) begin
        rd_ptr++; stall = 0;
      end else if (master_ready) begin
        stall++;
      end
      if (m_wr_req) begin
        m_wr_data = wdat[wr_idx % MB]; wr_idx++; n_wrreq++;
      end else begin
        m_wr_data = DW'($urandom);
      end
      if (poke_start && cyc == 8) begin
        m_start = 1'b1; m_addr = ~addr; m_mode = ~md; m_len = 1;
      end else begin
        m_start = 1'b0;
      end
      @(negedge clk);
    end
    m_start = 1'b0; bgrant = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; split = 1'b0;
  endtask

  // expected outcome of an error-free transaction from its parameters
  task automatic check_txn(input string tag, input logic [AW-1:0] addr, input logic md,
                           input int len);
    int   eff = eff_len(len);
    logic exp_bits [$];
    int   nb, nw, bad;
    for (int i = AW - 1; i >= 0; i--) exp_bits.push_back(addr[i]);
    if (md) begin
      for (int b = 0; b < eff; b++)
        for (int i = DW - 1; i >= 0; i--) exp_bits.push_back(wdat[b][i]);
    end
    check({tag, ".done"}, n_done, 1);
    check({tag, ".err"}, err_done, 0);
    check({tag, ".backoff"}, n_backoff, 0);
    check({tag, ".nbits"}, wr_bits.size(), exp_bits.size());
    nb = (wr_bits.size() < exp_bits.size()) ? wr_bits.size() : exp_bits.size();
    bad = 0;
    for (int i = 0; i < nb; i++) if (wr_bits[i] !== exp_bits[i]) bad++;
    check({tag, ".bit_errors"}, bad, 0);
    check({tag, ".wr_req"}, n_wrreq, md ? eff : 0);
    check({tag, ".nwords"}, rd_words.size(), md ? 0 : eff);
    nw = (rd_words.size() < eff) ? rd_words.size() : eff;
    if (!md) for (int i = 0; i < nw; i++) check($sformatf("%s.word%0d", tag, i), rd_words[i], rdat[i]);
    check({tag, ".idle_after"}, m_busy, 0);
  endtask

  initial begin
    int seen, cnt, nd;
    logic [AW-1:0] ra;
    logic          rm;
    logic [LW-1:0] rl;

    rstn = 1'b0; rd_bus = 0; ack = 0; slave_ready = 0; slave_valid = 0; bgrant = 0;
    split = 0; m_addr = '0; m_mode = 0; m_len = '0; m_start = 0; m_wr_data = '0;
    grant_pct = 100; ready_pct = 100; ack_v = 1'b1; split_len = 0; poke_start = 1'b0;
    #1;
    check("reset.outputs", {mode, wr_bus, master_valid, master_ready, breq, m_wr_req,
                            m_rd_data, m_rd_valid, m_busy, m_done, m_err}, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // directed write: address then A5, full rate
    wdat[0] = 8'hA5;
    run_txn(16'h1234, 1'b1, 1, 200);
    check_txn("wr1234", 16'h1234, 1'b1, 1);
    check("wr1234.latency", done_cyc, 2 + AW + 1 * (1 + DW));

    // directed read of three words
    rdat[0] = 8'h11; rdat[1] = 8'h22; rdat[2] = 8'h33; rdat[3] = 8'h44;
    run_txn(16'h5A0F, 1'b0, 3, 300);
    check_txn("rd3", 16'h5A0F, 1'b0, 3);
    check("rd3.latency", done_cyc, 2 + AW + 3 * DW);

    // no ack after the slave-select bits
    ack_v = 1'b0;
    run_txn(16'hC3A0, 1'b1, 2, 200);
    check("nack.done", n_done, 1);
    check("nack.err", err_done, 1);
    check("nack.breq_low", breq_done, 0);
    check("nack.nbits", wr_bits.size(), SB);
    if (wr_bits.size() == SB)
      check("nack.sel_bits", {wr_bits[0], wr_bits[1], wr_bits[2], wr_bits[3]}, 4'hC);
    check("nack.wr_req", n_wrreq, 0);
    check("nack.backoff", n_backoff, 0);
    repeat (2) @(negedge clk);
    check("nack.err_held", m_err, 1);
    ack_v = 1'b1;

    // slave never ready: timeout, retries, then error
    ready_pct = 0;
    run_txn(16'h0F0F, 1'b1, 1, 2000);
    check("tmo.done", n_done, 1);
    check("tmo.err", err_done, 1);
    check("tmo.backoffs", n_backoff, MR + 1);
    for (int i = 0; i < stall_runs.size(); i++)
      check($sformatf("tmo.stall%0d", i), stall_runs[i], TO - 1);
    check("tmo.wr_req", n_wrreq, 0);
    ready_pct = 100;

    // randomized transactions with stalls, grant delay and a stray m_start
    grant_pct = 60; ready_pct = 70;
    for (int k = 0; k < 6; k++) begin
      ra = AW'($urandom);
      rm = 1'($urandom);
      rl = LW'($urandom_range(0, 7));
      for (int b = 0; b < MB; b++) begin
        wdat[b] = DW'($urandom); rdat[b] = DW'($urandom);
      end
      poke_start = (k == 2);
      run_txn(ra, rm, rl, 2000);
      check_txn($sformatf("rand%0d", k), ra, rm, rl);
    end
    poke_start = 1'b0;

    // split held during a read longer than the timeout
    grant_pct = 100; ready_pct = 80; split_len = 80;
    for (int b = 0; b < MB; b++) rdat[b] = DW'($urandom);
    run_txn(16'h9876, 1'b0, 4, 3000);
    check_txn("split", 16'h9876, 1'b0, 4);
    split_len = 0; ready_pct = 100;

    // reset asserted in the middle of a write beat
    @(negedge clk);
    m_addr = 16'hBEEF; m_mode = 1'b1; m_len = 2; m_start = 1'b1;
    slave_ready = 1'b1; bgrant = 1'b1; ack = 1'b1;
    @(negedge clk);
    m_start = 1'b0;
    seen = 0; cnt = 0;
    for (int c = 0; c < 100 && cnt < 3; c++) begin
      if (m_wr_req) begin
        m_wr_data = 8'h3C; seen = 1;
      end else if (seen && master_valid) begin
        cnt++;
      end
      if (cnt < 3) @(negedge clk);
    end
    check("rst.in_wr_data", cnt, 3);
    #2 rstn = 1'b0;
    #1;
    check("rst.outputs", {mode, wr_bus, master_valid, master_ready, breq, m_wr_req,
                          m_rd_data, m_rd_valid, m_busy, m_done, m_err}, 0);
    nd = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_done) nd++;
    end
    check("rst.no_done", nd, 0);
    check("rst.busy_low", m_busy, 0);
    rstn = 1'b1; slave_ready = 1'b0; bgrant = 1'b0;
    @(negedge clk);
    check("rst.idle_after", {m_busy, breq}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/burst_master_port.md
BURST_MASTER_PORT -- requirements
Module: burst_master_port

Interface
REQ-001 Parameters (name, default, meaning):
- AW, 16, address width; upper SLAVE_BITS bits select the slave.
- DW, 8, data word width.
- SLAVE_BITS, 4, slave-select bits sent before the ack check.
- MAX_BURST, 4, maximum beats per transaction.
- TIMEOUT, 64, stall-cycle limit.
- MAX_RETRY, 3, re-arbitration attempts after a timeout.

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- mode, out, 1, 1 = write, 0 = read.
- wr_bus, out, 1, serial address/write data, MSB first.
- rd_bus, in, 1, serial read data, MSB first.
- ack, in, 1, slave address acknowledge.
- master_valid, out, 1, wr_bus bit valid.
- slave_ready, in, 1, slave accepts wr_bus bit.
- master_ready, out, 1, master accepts rd_bus bit.
- slave_valid, in, 1, rd_bus bit valid.
- breq, out, 1, bus request.
- bgrant, in, 1, bus grant.
- split, in, 1, slave split.
- m_addr, in, AW, start address.
- m_mode, in, 1, transaction mode.
- m_len, in, clog2(MAX_BURST)+1, beat count.
- m_start, in, 1, start pulse.
- m_wr_data, in, DW, write beat.
- m_wr_req, out, 1, one-cycle pulse: m_wr_data sampled this cycle.
- m_rd_data, out, DW, read beat.
- m_rd_valid, out, 1, one-cycle pulse: m_rd_data valid.
- m_busy, out, 1, transaction in progress.
- m_done, out, 1, one-cycle completion pulse.
- m_err, out, 1, error status, valid with m_done.

Function
REQ-003 States SHALL be: IDLE, REQ, FETCH, ADDR_1, ADDR_2, LOAD, WR_DATA, RD_DATA, SPLIT, BACKOFF, DONE.
REQ-004 Transitions:
- IDLE->REQ on m_start; m_addr, m_mode and m_len latch that cycle. m_start outside IDLE is ignored.
- m_len of 0 or greater than MAX_BURST latches as MAX_BURST.
- REQ->FETCH on bgrant; FETCH->ADDR_1 unconditionally.
REQ-005 Bit transfer: one bit per cycle with master_valid & slave_ready (write direction) or master_ready & slave_valid (read direction).
- A cycle without a transfer holds all shift registers and counters.
REQ-006 ADDR_1 sends SLAVE_BITS bits. ack is sampled in the cycle the last of these bits transfers:
- ack=1 -> ADDR_2.
- ack=0 -> DONE with m_err=1 and no retry.
REQ-007 ADDR_2 sends the remaining AW-SLAVE_BITS bits, then goes to LOAD if mode=1, or to RD_DATA if mode=0.
REQ-008 LOAD lasts one cycle, pulses m_wr_req and captures m_wr_data, then goes to WR_DATA.
- WR_DATA sends DW bits.
- After the final beat -> DONE; otherwise -> LOAD.
REQ-009 RD_DATA shifts in DW bits.
- On each completed word: m_rd_valid pulses for one cycle with m_rd_data held stable until the next word.
- After the final beat -> DONE.
REQ-010 Stall timeout:
- The timeout counter clears on every bit transfer and on entry to FETCH, and increments on stall cycles in ADDR_1, ADDR_2, WR_DATA and RD_DATA.
- On reaching TIMEOUT-1 -> BACKOFF.
REQ-011 BACKOFF lasts one cycle with breq=0 and increments the retry counter.
- If retries < MAX_RETRY: -> REQ and the transaction restarts from beat 0.
- Otherwise: -> DONE with m_err=1.
REQ-012 DONE lasts one cycle, pulses m_done, clears all counters, then goes to IDLE. m_err holds until the next m_start.
REQ-013 Output rules:
- breq=1 in every state except IDLE, BACKOFF and DONE.
- master_valid=1 in ADDR_1, ADDR_2 and WR_DATA.
- master_ready=1 in RD_DATA only.
- m_busy=1 whenever not in IDLE.
REQ-014 The address is transmitted once per burst; the slave increments the address internally.

Reset
REQ-015 Reset SHALL be asynchronous and active-low on rstn, forcing IDLE immediately.
- All outputs go to 0.
- All shift registers and counters go to 0.
REQ-016 Reset mid-transaction SHALL abort the transaction with no m_done pulse.

Configuration
REQ-017 Macro BURST_MASTER_PORT_SPLIT_EN.
- Defined: split=1 in RD_DATA -> SPLIT. SPLIT holds breq=1 and the bit/beat counters, returns to RD_DATA when split=0, and stalls the timeout counter.
- Undefined: split is ignored and SPLIT is unreachable.

Verification
REQ-018 Directed scenarios:
- Write, m_addr=0x1234, len=1, data 0xA5, slave_ready=1 -> wr_bus sends 16 address bits then 10100101; one m_done, m_err=0.
- Read, len=3, slave returns 0x11, 0x22, 0x33 -> three m_rd_valid pulses with matching data; m_done.
- ack=0 at the 4th bit -> m_done with m_err=1, breq drops, no data phase.
- slave_ready held 0 -> BACKOFF after 63 stall cycles; after 3 retries m_done with m_err=1.
- With SPLIT_EN, split asserted for 10 cycles during a read -> data unchanged, no timeout.
- rstn low during WR_DATA -> immediate IDLE, all outputs 0, no m_done.
